// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction memory request/acknowledge bundle
interface if_fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC, imem request FSM, IF/ID register
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pa_pc_ifid_i,
   input  logic                     wash_ifid_i,
   input  logic                     redirect_valid_i,
   input  logic [31:0]              redirect_pc_i,
   if_fetch_stage_if.master         imem,
   output logic                     ifid_valid_o,
   output logic [31:0]              ifid_pc_o,
   output logic [31:0]              ifid_instr_o,
   output logic                     ifid_adel_o
);

   typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic        ifid_adel_q, ifid_adel_d;

   logic        aligned;
   logic        req_raw;
   logic [31:0] addr_sel;
   logic        res_avail;
   logic [31:0] res_instr;
   logic        res_adel;
   logic        capture;
   logic        load;

   assign aligned = (pc_q[1:0] == 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (redirect_valid_i) begin
               if (aligned && !imem.ack) state_d = S_DROP;
            end else if (aligned && imem.ack && pa_pc_ifid_i) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect_valid_i || (!pa_pc_ifid_i && !wash_ifid_i)) state_d = S_FETCH;
         end
         S_DROP: begin
            if (imem.ack) state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // S_DROP keeps presenting the abandoned address so the bus sees a stable request until ack.
   always_comb begin
      req_raw   = 1'b0;
      addr_sel  = pc_q;
      res_avail = 1'b0;
      res_instr = 32'h0;
      res_adel  = 1'b0;
      capture   = 1'b0;
      case (state_q)
         S_FETCH: begin
            req_raw = aligned;
            if (!aligned) begin
               res_avail = 1'b1;
               res_adel  = 1'b1;
            end else if (imem.ack) begin
               res_avail = 1'b1;
               res_instr = imem.rdata;
            end
            capture = aligned && imem.ack && pa_pc_ifid_i && !redirect_valid_i;
         end
         S_HOLD: begin
            res_avail = 1'b1;
            res_instr = buf_q;
         end
         S_DROP: begin
            req_raw  = 1'b1;
            addr_sel = drop_addr_q;
         end
         default: ;
      endcase
   end

   assign imem.req  = req_raw && !rst;
   assign imem.addr = addr_sel;

   assign load = !wash_ifid_i && !pa_pc_ifid_i && !redirect_valid_i && res_avail;

   always_comb begin
      pc_d         = redirect_valid_i ? redirect_pc_i : (load ? pc_q + 32'd4 : pc_q);
      buf_d        = capture ? imem.rdata : buf_q;
      drop_addr_d  = (state_q == S_DROP) ? drop_addr_q : pc_q;
      ifid_valid_d = 1'b0;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = 32'h0;
      ifid_adel_d  = 1'b0;
      if (!wash_ifid_i && pa_pc_ifid_i) begin
         ifid_valid_d = ifid_valid_q;
         ifid_instr_d = ifid_instr_q;
         ifid_adel_d  = ifid_adel_q;
      end else if (load) begin
         ifid_valid_d = 1'b1;
         ifid_pc_d    = pc_q;
         ifid_instr_d = res_instr;
         ifid_adel_d  = res_adel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         buf_q        <= 32'h0;
         drop_addr_q  <= RESET_PC;
         ifid_valid_q <= 1'b0;
         ifid_pc_q    <= RESET_PC;
         ifid_instr_q <= 32'h0;
         ifid_adel_q  <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         buf_q        <= buf_d;
         drop_addr_q  <= drop_addr_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_adel_q  <= ifid_adel_d;
      end
   end

   assign ifid_valid_o = ifid_valid_q;
   assign ifid_pc_o    = ifid_pc_q;
   assign ifid_instr_o = ifid_instr_q;
   assign ifid_adel_o  = ifid_adel_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized self-checking bench for if_fetch_stage
module tb_if_fetch_stage;
   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        pa, wash, rv;
   logic [31:0] rpc;
   logic        ifid_valid, ifid_adel;
   logic [31:0] ifid_pc, ifid_instr;

   if_fetch_stage_if imem();

   if_fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk              (clk),
      .rst              (rst),
      .pa_pc_ifid_i     (pa),
      .wash_ifid_i      (wash),
      .redirect_valid_i (rv),
      .redirect_pc_i    (rpc),
      .imem             (imem),
      .ifid_valid_o     (ifid_valid),
      .ifid_pc_o        (ifid_pc),
      .ifid_instr_o     (ifid_instr),
      .ifid_adel_o      (ifid_adel)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: PC, a "word waiting for the stall to clear", and an "abandoned request in flight".
   logic [31:0] m_pc, m_held_word, m_drop_addr;
   bit          m_held, m_drop;
   logic        e_valid, e_adel;
   logic [31:0] e_pc, e_instr;
   bit          mem_busy;
   int          mem_wait;
   bit          prev_pend;
   logic [31:0] prev_addr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit exp_req();
      return !m_held && (m_drop || m_pc[1:0] == 2'b00);
   endfunction

   function automatic logic [31:0] exp_addr();
      return m_drop ? m_drop_addr : m_pc;
   endfunction

   task automatic model_reset();
      m_pc = RST_PC; m_held = 0; m_drop = 0; m_held_word = 0; m_drop_addr = 0;
      e_valid = 0; e_pc = RST_PC; e_instr = 0; e_adel = 0;
      mem_busy = 0; mem_wait = 0; prev_pend = 0; prev_addr = 0;
   endtask

   task automatic check_ifid();
      check("ifid_valid", ifid_valid, e_valid);
      check("ifid_pc", ifid_pc, e_pc);
      check("ifid_instr", ifid_instr, e_instr);
      check("ifid_adel", ifid_adel, e_adel);
   endtask

   // Called just after a rising edge; drives one cycle of inputs and checks the resulting edge.
   task automatic step(input bit p, input bit w, input bit r, input logic [31:0] rp, input bit a);
      bit          has, ra, loaded, al;
      logic [31:0] ri;
      check("req", imem.req, exp_req());
      if (exp_req()) check("addr", imem.addr, exp_addr());
      if (prev_pend) begin
         check("req_held", imem.req, 1);
         check("addr_stable", imem.addr, prev_addr);
      end
      pa = p; wash = w; rv = r; rpc = rp;
      imem.ack   = a && imem.req;
      imem.rdata = $urandom;

      al = (m_pc[1:0] == 2'b00);
      has = 0; ra = 0; ri = 32'h0;
      if (m_held) begin
         has = 1; ri = m_held_word;
      end else if (!m_drop) begin
         if (!al) begin has = 1; ra = 1; end
         else if (imem.ack) begin has = 1; ri = imem.rdata; end
      end
      loaded = !w && !p && !r && has;
      if (w) begin
         e_valid = 0; e_instr = 0; e_adel = 0;
      end else if (!p) begin
         if (loaded) begin
            e_valid = 1; e_pc = m_pc; e_instr = ri; e_adel = ra;
         end else begin
            e_valid = 0; e_instr = 0; e_adel = 0;
         end
      end
      if (m_drop) begin
         if (imem.ack) m_drop = 0;
      end else if (m_held) begin
         if (r || loaded) m_held = 0;
      end else if (al && !imem.ack && r) begin
         m_drop = 1; m_drop_addr = m_pc;
      end else if (al && imem.ack && p && !r) begin
         m_held = 1; m_held_word = imem.rdata;
      end
      if (r) m_pc = rp;
      else if (loaded) m_pc = m_pc + 32'd4;

      prev_pend = imem.req && !imem.ack;
      prev_addr = imem.addr;
      @(posedge clk); #1;
      check_ifid();
   endtask

   task automatic rand_step();
      bit          p, w, r, a;
      logic [31:0] rp;
      int          sel;
      p = ($urandom % 4) == 0;
      w = ($urandom % 8) == 0;
      r = ($urandom % 10) == 0;
      sel = $urandom % 8;
      if (sel == 0)      rp = $urandom | 32'h1;
      else if (sel == 1) rp = 32'hFFFF_FFFC;
      else               rp = $urandom & ~32'h3;
      a = 0;
      if (imem.req) begin
         if (!mem_busy) begin
            mem_busy = 1;
            mem_wait = $urandom % 3;
         end
         a = (mem_wait == 0);
         if (a) mem_busy = 0;
         else   mem_wait--;
      end
      step(p, w, r, rp, a);
   endtask

   initial begin
      rst = 1; pa = 0; wash = 0; rv = 0; rpc = 0;
      imem.ack = 0; imem.rdata = 0;
      model_reset();
      #2;
      check("rst_req", imem.req, 0);
      check_ifid();
      repeat (2) @(posedge clk);
      #1 rst = 0;
      #1;
      check("first_req", imem.req, 1);
      check("first_addr", imem.addr, RST_PC);

      // Zero-wait streaming
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 1);
         check("stream_pc", ifid_pc, RST_PC + 32'd4 * i);
         check("stream_valid", ifid_valid, 1);
      end
      // Late ack
      repeat (3) begin
         step(0, 0, 0, 0, 0);
         check("late_bubble", ifid_valid, 0);
      end
      step(0, 0, 0, 0, 1);
      check("late_pc", ifid_pc, 32'hBFC0_0010);
      // Ack under stall, then release
      step(1, 0, 0, 0, 1);
      check("hold_req", imem.req, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("hold_load_pc", ifid_pc, 32'hBFC0_0014);
      check("hold_next_addr", imem.addr, 32'hBFC0_0018);
      // Redirect with request pending -> late ack dropped
      step(0, 0, 1, 32'h8000_0180, 0);
      step(0, 0, 0, 0, 1);
      check("drop_bubble", ifid_valid, 0);
      check("drop_next_addr", imem.addr, 32'h8000_0180);
      // Redirect with ack in same cycle, to a misaligned address
      step(0, 0, 1, 32'h8000_0002, 1);
      check("adel_no_req", imem.req, 0);
      step(0, 0, 0, 0, 0);
      check("adel_valid", ifid_valid, 1);
      check("adel_flag", ifid_adel, 1);
      check("adel_instr", ifid_instr, 0);
      check("adel_pc", ifid_pc, 32'h8000_0002);
      step(0, 0, 1, 32'h0000_1000, 0);
      // Wash during stall
      step(1, 1, 0, 0, 1);
      check("wash_bubble", ifid_valid, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("wash_buf_pc", ifid_pc, 32'h0000_1000);
      // Reset in the middle of a dropped request
      step(0, 0, 1, 32'h0000_2000, 0);
      rst = 1;
      #1;
      check("rst_drop_req", imem.req, 0);
      check("rst_drop_valid", ifid_valid, 0);
      check("rst_drop_pc", ifid_pc, RST_PC);
      check("rst_drop_instr", ifid_instr, 0);
      check("rst_drop_adel", ifid_adel, 0);
      model_reset();
      @(posedge clk); #1 rst = 0;
      #1;
      check("rerst_addr", imem.addr, RST_PC);
      imem.ack = 0;

      repeat (800) rand_step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
